// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle RV-style datapath with a shared instruction/data
// memory. It steps through fetch, decode, execute, memory access and write-back, waits
// on a memory ready handshake, counts retired instructions, and parks in a sticky HALT
// state on an illegal encoding or a memory timeout.
module multicycle_control_fsm #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       instr_opcode,
    input  logic [2:0]       instr_funct3,
    input  logic             instr_funct7_b5,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic             alu_src_b,
    output logic [3:0]       alu_op,
    output logic             reg_write,
    output logic             wb_sel,
    output logic             busy,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMem       = 3'd4,
        StWriteback = 3'd5,
        StHalt      = 3'd6,
        StUnused    = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        ClsAdd   = 3'd0,
        ClsSub   = 3'd1,
        ClsLsl   = 3'd2,
        ClsAddi  = 3'd3,
        ClsLoad  = 3'd4,
        ClsStore = 3'd5
    } cls_e;

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    // Last wait-counter value at which a missing mem_ready is still tolerated.
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    cls_e             dec_cls;
    logic             dec_ok;
    logic [3:0]       cls_alu_op;
    logic             cls_imm;
    logic             cls_mem;

    // Classify the instruction fields presented during DECODE.
    always_comb begin
        dec_cls = ClsAdd;
        dec_ok  = 1'b0;
        unique case (instr_opcode)
            OpReg: begin
                if (instr_funct3 == 3'b000) begin
                    dec_cls = instr_funct7_b5 ? ClsSub : ClsAdd;
                    dec_ok  = 1'b1;
                end else if (instr_funct3 == 3'b001 && !instr_funct7_b5) begin
                    dec_cls = ClsLsl;
                    dec_ok  = 1'b1;
                end
            end
            OpImm: begin
                dec_cls = ClsAddi;
                dec_ok  = (instr_funct3 == 3'b000);
            end
            OpLoad: begin
                dec_cls = ClsLoad;
                dec_ok  = (instr_funct3 == 3'b010);
            end
            OpStore: begin
                dec_cls = ClsStore;
                dec_ok  = (instr_funct3 == 3'b010);
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // ALU controls implied by the registered instruction class.
    always_comb begin
        cls_alu_op = 4'b0001;
        cls_imm    = 1'b1;
        unique case (cls_q)
            ClsAdd: begin cls_alu_op = 4'b0000; cls_imm = 1'b0; end
            ClsSub: begin cls_alu_op = 4'b0011; cls_imm = 1'b0; end
            ClsLsl: begin cls_alu_op = 4'b0010; cls_imm = 1'b0; end
            default: begin cls_alu_op = 4'b0001; cls_imm = 1'b1; end
        endcase
        cls_mem = (cls_q == ClsLoad) || (cls_q == ClsStore);
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        wait_d       = 8'd0;  // cleared unless a memory state keeps waiting
        count_d      = count_q;
        illegal_d    = illegal_q;
        timeout_d    = timeout_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = 4'b0000;
        reg_write    = 1'b0;
        wb_sel       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (wait_q == WaitLast) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: begin
                if (dec_ok) begin
                    cls_d   = dec_cls;
                    state_d = StExecute;
                end else begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end
            end
            StExecute: begin
                alu_op    = cls_alu_op;
                alu_src_b = cls_imm;
                state_d   = cls_mem ? StMem : StWriteback;
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == ClsStore);
                alu_op       = cls_alu_op;
                alu_src_b    = cls_imm;
                if (mem_ready) begin
                    if (cls_q == ClsStore) begin
                        count_d = count_q + CNT_W'(1);
                        state_d = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (wait_q == WaitLast) begin
                    state_d   = StHalt;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWriteback: begin
                reg_write = 1'b1;
                wb_sel    = (cls_q == ClsLoad);
                count_d   = count_q + CNT_W'(1);
                state_d   = StFetch;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, class, wait counter, retire counter and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cls_q     <= ClsAdd;
            wait_q    <= 8'd0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy        = (state_q != StIdle) && (state_q != StHalt);
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Each step drives inputs on the falling
// edge, queues the expected output vector, and compares it 1 ns later.
module tb_multicycle_control_fsm;

    localparam int unsigned CNT_W = 16;

    localparam logic [6:0] OpReg   = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;

    logic             clk;
    logic             reset;
    logic             start;
    logic [6:0]       instr_opcode;
    logic [2:0]       instr_funct3;
    logic             instr_funct7_b5;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             mem_addr_sel;
    logic             ir_write;
    logic             pc_write;
    logic             alu_src_b;
    logic [3:0]       alu_op;
    logic             reg_write;
    logic             wb_sel;
    logic             busy;
    logic             illegal;
    logic             timeout;
    logic [2:0]       state;
    logic [CNT_W-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    multicycle_control_fsm #(.CNT_W(CNT_W), .MAX_WAIT(15)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .instr_opcode    (instr_opcode),
        .instr_funct3    (instr_funct3),
        .instr_funct7_b5 (instr_funct7_b5),
        .mem_ready       (mem_ready),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr_sel    (mem_addr_sel),
        .ir_write        (ir_write),
        .pc_write        (pc_write),
        .alu_src_b       (alu_src_b),
        .alu_op          (alu_op),
        .reg_write       (reg_write),
        .wb_sel          (wb_sel),
        .busy            (busy),
        .illegal         (illegal),
        .timeout         (timeout),
        .state           (state),
        .instr_count     (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed order: state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write,
    // alu_src_b, alu_op, reg_write, wb_sel, busy, illegal, timeout, instr_count.
    function automatic logic [33:0] ev(input logic [2:0] st, input logic req, input logic we,
                                       input logic asel, input logic irw, input logic pcw,
                                       input logic srcb, input logic [3:0] op, input logic rw,
                                       input logic wbs, input logic bsy, input logic ill,
                                       input logic to, input logic [15:0] cnt);
        return {st, req, we, asel, irw, pcw, srcb, op, rw, wbs, bsy, ill, to, cnt};
    endfunction

    function automatic logic [33:0] e_idle(input logic [15:0] cnt);
        return ev(3'd0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, cnt);
    endfunction
    function automatic logic [33:0] e_fetch(input logic rdy, input logic [15:0] cnt);
        return ev(3'd1, 1, 0, 0, rdy, rdy, 0, 4'd0, 0, 0, 1, 0, 0, cnt);
    endfunction
    function automatic logic [33:0] e_dec(input logic [15:0] cnt);
        return ev(3'd2, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, 0, 0, cnt);
    endfunction
    function automatic logic [33:0] e_exe(input logic [3:0] op, input logic srcb,
                                          input logic [15:0] cnt);
        return ev(3'd3, 0, 0, 0, 0, 0, srcb, op, 0, 0, 1, 0, 0, cnt);
    endfunction
    function automatic logic [33:0] e_mem(input logic we, input logic [15:0] cnt);
        return ev(3'd4, 1, we, 1, 0, 0, 1, 4'b0001, 0, 0, 1, 0, 0, cnt);
    endfunction
    function automatic logic [33:0] e_wb(input logic wbs, input logic [15:0] cnt);
        return ev(3'd5, 0, 0, 0, 0, 0, 0, 4'd0, 1, wbs, 1, 0, 0, cnt);
    endfunction
    function automatic logic [33:0] e_halt(input logic ill, input logic to,
                                           input logic [15:0] cnt);
        return ev(3'd6, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, ill, to, cnt);
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        instr_opcode    = op;
        instr_funct3    = f3;
        instr_funct7_b5 = f7;
    endtask

    // One clock cycle: drive inputs, queue expectation, compare, advance to next negedge.
    task automatic cyc(input logic rst, input logic st, input logic rdy,
                       input logic [33:0] exp, input string tag);
        logic [33:0] obs;
        logic [33:0] e;
        reset     = rst;
        start     = st;
        mem_ready = rdy;
        exp_q.push_back(exp);
        #1;
        obs = {state, mem_req, mem_we, mem_addr_sel, ir_write, pc_write, alu_src_b, alu_op,
               reg_write, wb_sel, busy, illegal, timeout, instr_count};
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mem_ready = 1'b0;
        set_instr(OpReg, 3'b000, 1'b0);
        @(negedge clk);

        // ADD, zero wait states, followed by LOAD with 3 wait cycles, ADDI and LSL.
        cyc(1, 0, 0, e_idle(0), "reset");
        cyc(0, 0, 1, e_idle(0), "idle_hold");
        cyc(0, 1, 1, e_idle(0), "idle_start");
        cyc(0, 0, 1, e_fetch(1, 0), "add_fetch");
        cyc(0, 0, 1, e_dec(0), "add_decode");
        cyc(0, 0, 1, e_exe(4'b0000, 0, 0), "add_exec");
        cyc(0, 0, 1, e_wb(0, 0), "add_wb");
        set_instr(OpLoad, 3'b010, 1'b0);
        cyc(0, 0, 1, e_fetch(1, 1), "ld_fetch");
        cyc(0, 0, 1, e_dec(1), "ld_decode");
        cyc(0, 0, 1, e_exe(4'b0001, 1, 1), "ld_exec");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, e_mem(0, 1), "ld_mem_wait");
        cyc(0, 0, 1, e_mem(0, 1), "ld_mem_ready");
        cyc(0, 0, 1, e_wb(1, 1), "ld_wb");
        set_instr(OpImm, 3'b000, 1'b0);
        cyc(0, 0, 1, e_fetch(1, 2), "addi_fetch");
        cyc(0, 0, 1, e_dec(2), "addi_decode");
        cyc(0, 0, 1, e_exe(4'b0001, 1, 2), "addi_exec");
        cyc(0, 0, 1, e_wb(0, 2), "addi_wb");
        set_instr(OpReg, 3'b001, 1'b0);
        cyc(0, 1, 1, e_fetch(1, 3), "lsl_fetch");
        cyc(0, 0, 1, e_dec(3), "lsl_decode");
        cyc(0, 0, 1, e_exe(4'b0010, 0, 3), "lsl_exec");
        cyc(0, 0, 1, e_wb(0, 3), "lsl_wb");
        cyc(0, 0, 0, e_fetch(0, 4), "count4");

        // STORE then SUB.
        cyc(1, 0, 0, e_idle(0), "reset2");
        set_instr(OpStore, 3'b010, 1'b0);
        cyc(0, 1, 1, e_idle(0), "st_start");
        cyc(0, 0, 1, e_fetch(1, 0), "st_fetch");
        cyc(0, 0, 1, e_dec(0), "st_decode");
        cyc(0, 0, 1, e_exe(4'b0001, 1, 0), "st_exec");
        cyc(0, 0, 1, e_mem(1, 0), "st_mem");
        set_instr(OpReg, 3'b000, 1'b1);
        cyc(0, 0, 1, e_fetch(1, 1), "sub_fetch");
        cyc(0, 0, 1, e_dec(1), "sub_decode");
        cyc(0, 0, 1, e_exe(4'b0011, 0, 1), "sub_exec");
        cyc(0, 0, 1, e_wb(0, 1), "sub_wb");
        cyc(0, 0, 0, e_fetch(0, 2), "count2");

        // Illegal R-type encoding halts; start is ignored afterwards.
        cyc(1, 0, 0, e_idle(0), "reset3");
        set_instr(OpReg, 3'b001, 1'b1);
        cyc(0, 1, 1, e_idle(0), "ill_start");
        cyc(0, 0, 1, e_fetch(1, 0), "ill_fetch");
        cyc(0, 0, 1, e_dec(0), "ill_decode");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, e_halt(1, 0, 0), "ill_halt");

        // Fetch timeout after 15 cycles without mem_ready.
        cyc(1, 0, 0, e_idle(0), "reset4");
        set_instr(OpReg, 3'b000, 1'b0);
        cyc(0, 1, 0, e_idle(0), "to_start");
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, e_fetch(0, 0), "to_fetch_wait");
        cyc(0, 1, 1, e_halt(0, 1, 0), "to_halt");
        cyc(0, 0, 1, e_halt(0, 1, 0), "to_halt_hold");

        // mem_ready on the 15th fetch cycle is accepted.
        cyc(1, 0, 0, e_idle(0), "reset5");
        cyc(0, 1, 0, e_idle(0), "edge_start");
        for (int i = 0; i < 14; i++) cyc(0, 0, 0, e_fetch(0, 0), "edge_fetch_wait");
        cyc(0, 0, 1, e_fetch(1, 0), "edge_fetch15");
        cyc(0, 0, 1, e_dec(0), "edge_decode");

        // Reset in the middle of a STORE wait, then restart.
        cyc(1, 0, 0, e_idle(0), "reset6");
        set_instr(OpStore, 3'b010, 1'b0);
        cyc(0, 1, 1, e_idle(0), "rs_start");
        cyc(0, 0, 1, e_fetch(1, 0), "rs_fetch");
        cyc(0, 0, 1, e_dec(0), "rs_decode");
        cyc(0, 0, 1, e_exe(4'b0001, 1, 0), "rs_exec");
        cyc(0, 0, 1, e_mem(1, 0), "rs_mem");
        cyc(0, 0, 1, e_fetch(1, 1), "rs_fetch2");
        cyc(0, 0, 1, e_dec(1), "rs_decode2");
        cyc(0, 0, 1, e_exe(4'b0001, 1, 1), "rs_exec2");
        cyc(0, 0, 0, e_mem(1, 1), "rs_mem_wait");
        cyc(0, 0, 0, e_mem(1, 1), "rs_mem_wait2");
        cyc(1, 0, 0, e_idle(0), "rst_in_mem");
        cyc(0, 1, 1, e_idle(0), "resume_start");
        cyc(0, 0, 1, e_fetch(1, 0), "resume_fetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control state machine that sequences a multicycle version of the RV-style datapath: single shared instruction/data memory, 32-entry register file, 4-bit-opcode ALU.
- Fetches through the shared memory port, decodes R-type/ADDI/load/store, drives ALU, memory and write-back strobes state by state.
- Waits on a memory ready handshake, counts retired instructions, traps illegal encodings and memory timeouts into a sticky HALT state.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- MAX_WAIT, 15, maximum cycles to wait for mem_ready in any memory state before timeout (legal range 1..255).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins execution from IDLE
- instr_opcode  input  7  IR[6:0], stable from the cycle after ir_write
- instr_funct3  input  3  IR[14:12]
- instr_funct7_b5  input  1  IR[30]
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory access request
- mem_we  output  1  write strobe (valid only with mem_req)
- mem_addr_sel  output  1  0 = PC, 1 = ALU result
- ir_write  output  1  latch read data into IR
- pc_write  output  1  PC <= PC + 4
- alu_src_b  output  1  0 = rs2 register, 1 = immediate
- alu_op  output  4  0000 ADD, 0001 ADDI, 0010 LSL, 0011 SUB
- reg_write  output  1  write rd this cycle
- wb_sel  output  1  0 = ALU result, 1 = memory data
- busy  output  1  state not IDLE and not HALT
- illegal  output  1  sticky: halted on illegal encoding
- timeout  output  1  sticky: halted on mem_ready timeout
- state  output  3  current state code
- instr_count  output  CNT_W  retired instruction count

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6. Code 7 is unreachable; if entered, go to IDLE next cycle.
- Reset (async, any state, mid-access included):
  - state=IDLE; instr_count=0; illegal=0; timeout=0; wait counter=0.
  - All strobes 0; alu_op=0000.
- Control outputs are combinational from state plus the instruction class registered in DECODE. Strobes are 0 in any state where this list does not assert them.
- IDLE: start=1 -> FETCH; otherwise stay. start is ignored in every other state.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - mem_ready=1 -> ir_write=1, pc_write=1 in the same cycle -> DECODE.
  - Otherwise stay and increment the wait counter.
- DECODE: classify instr_opcode/funct fields, register the class, then go to EXECUTE or HALT.
  - 0110011, funct3=000 -> SUB if funct7_b5 else ADD.
  - 0110011, funct3=001, funct7_b5=0 -> LSL.
  - 0010011, funct3=000 -> ADDI.
  - 0000011, funct3=010 -> LOAD.
  - 0100011, funct3=010 -> STORE.
  - Any other encoding -> HALT with illegal=1.
- EXECUTE: alu_op per class.
  - R-type: alu_src_b=0.
  - ADDI: alu_op=0001, alu_src_b=1.
  - LOAD and STORE: alu_op=0001, alu_src_b=1 (address = rs1 + imm).
  - R-type and ADDI -> WRITEBACK. LOAD and STORE -> MEM.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE; alu_op/alu_src_b held as in EXECUTE.
  - mem_ready=1: STORE retires -> FETCH; LOAD -> WRITEBACK.
  - Otherwise stay and increment the wait counter.
- WRITEBACK: reg_write=1; wb_sel=1 for LOAD, else 0; instruction retires -> FETCH.
- Retire: instr_count increments by 1 on the retiring cycle and wraps from 2^CNT_W-1 to 0 without a flag.
- Wait counter:
  - Cleared on entry to FETCH or MEM and on every handshake.
  - If mem_ready is still 0 when the counter equals MAX_WAIT-1, the next state is HALT with timeout=1. With MAX_WAIT=15, mem_ready on the 15th cycle in the state is accepted; the 16th cycle never occurs.
- HALT: all strobes 0, busy=0, illegal/timeout held. Exit only via reset.
- Latency at zero wait-states (mem_ready=1 on the first request cycle): R-type/ADDI 4 cycles, STORE 4, LOAD 5, start-to-first-FETCH 1.

Test Plan:
- reset, start, ADD x13=x11+x12 with mem_ready tied 1 -> states 1,2,3,5,1; alu_op=0000; reg_write pulses once on cycle 4; instr_count=1.
- LOAD (0000011/010), mem_ready low 3 cycles in MEM -> mem_req=1, mem_addr_sel=1 held 4 cycles; then WRITEBACK with wb_sel=1, reg_write=1; total 8 cycles; instr_count +1.
- STORE then SUB (funct7_b5=1) -> mem_we=1 only in MEM for STORE; SUB gives alu_op=0011; no reg_write for STORE; instr_count=2.
- Opcode 0110011 with funct3=001 and funct7_b5=1 -> HALT, illegal=1, busy=0; later start pulses ignored; instr_count unchanged.
- FETCH with mem_ready never asserted, MAX_WAIT=15 -> HALT after 15 FETCH cycles, timeout=1; a run with mem_ready on the 15th cycle instead proceeds to DECODE.
- reset asserted in MEM during a STORE wait -> same cycle: state=0, mem_we=0, mem_req=0, instr_count=0; a new start resumes from FETCH.
